// File: rtl/register_bank.sv
// 32-entry register file: two combinational read ports, one synchronous write port.
// Optional same-cycle write-to-read forwarding is enabled by defining REGBANK_BYPASS_EN.
module register_bank #(
    parameter int          DATA_W  = 32,
    parameter int unsigned SP_INIT = 227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [4:0]        ReadReg1,
    input  logic [4:0]        ReadReg2,
    input  logic [4:0]        WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam logic [4:0]        SP_IDX = 5'd29;
    localparam logic [DATA_W-1:0] SP_VAL = DATA_W'(SP_INIT);

    logic [DATA_W-1:0] regs [0:31];
    logic              write_en;
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;

    assign write_en = RegWrite && (WriteReg != 5'd0);

    // Entry 0 is only ever loaded with zero; reads of index 0 are forced to zero below anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (5'(i) == SP_IDX) ? SP_VAL : '0;
            end
        end else if (write_en) begin
            regs[WriteReg] <= WriteData;
        end
    end

    always_comb begin
        stored1 = '0;
        stored2 = '0;
        if (ReadReg1 != 5'd0) stored1 = regs[ReadReg1];
        if (ReadReg2 != 5'd0) stored2 = regs[ReadReg2];
    end

`ifdef REGBANK_BYPASS_EN
    logic fwd1;
    logic fwd2;

    assign fwd1 = write_en && !reset && (WriteReg == ReadReg1);
    assign fwd2 = write_en && !reset && (WriteReg == ReadReg2);

    assign ReadData1 = fwd1 ? WriteData : stored1;
    assign ReadData2 = fwd2 ? WriteData : stored2;
`else
    assign ReadData1 = stored1;
    assign ReadData2 = stored2;
`endif

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed vector table plus hand sequences
// for reset, r0 discard, forwarding and reset-over-write behaviour.
module tb_register_bank;

    localparam int DATA_W = 32;
    localparam logic [31:0] SP_EXP = 32'd227;

    logic              clk = 1'b0;
    logic              reset;
    logic              RegWrite;
    logic [4:0]        ReadReg1;
    logic [4:0]        ReadReg2;
    logic [4:0]        WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [0:31];

    register_bank #(.DATA_W(DATA_W), .SP_INIT(227)) dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    always #5 clk = ~clk;

    // An unknown destination index during a write is a protocol violation.
    always @(posedge clk) begin
        if (RegWrite === 1'b1 && reset === 1'b0)
            assert (!$isunknown(WriteReg))
            else $error("WriteReg unknown while RegWrite=1");
    end

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = (i == 29) ? SP_EXP : 32'd0;
    endtask

    task automatic scan_all(input string tag);
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            ReadReg2 = 5'(31 - i);
            #1;
            chk($sformatf("%s_p1_r%0d", tag, i), ReadData1, model[i]);
            chk($sformatf("%s_p2_r%0d", tag, 31 - i), ReadData2, model[31 - i]);
        end
    endtask

    initial begin
        reset     = 1'b1;
        RegWrite  = 1'b0;
        ReadReg1  = 5'd0;
        ReadReg2  = 5'd0;
        WriteReg  = 5'd0;
        WriteData = '0;

        vecs[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd1,  5'd29, 32'h0,        SP_EXP};
        vecs[1] = '{1'b0, 5'd5,  32'hFFFFFFFF, 5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd5,  5'd8,  32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd29, 5'd8,  SP_EXP,       32'hDEADBEEF};
        vecs[5] = '{1'b1, 5'd31, 32'h11111111, 5'd0,  5'd1,  32'h0,        32'h0};
        vecs[6] = '{1'b0, 5'd31, 32'h0,        5'd31, 5'd31, 32'h11111111, 32'h11111111};
        vecs[7] = '{1'b1, 5'd1,  32'h00000001, 5'd31, 5'd0,  32'h11111111, 32'h0};
        vecs[8] = '{1'b0, 5'd3,  32'hAAAAAAAA, 5'd1,  5'd8,  32'h00000001, 32'hDEADBEEF};

        // Reset then full read-back
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        scan_all("rst");

        // Directed table: reads sampled before the edge, write lands at the edge
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            RegWrite  = vecs[v].we;
            WriteReg  = vecs[v].wr;
            WriteData = vecs[v].wd;
            ReadReg1  = vecs[v].r1;
            ReadReg2  = vecs[v].r2;
            #1;
            chk($sformatf("vec%0d_rd1", v), ReadData1, vecs[v].e1);
            chk($sformatf("vec%0d_rd2", v), ReadData2, vecs[v].e2);
            if (vecs[v].we && vecs[v].wr != 5'd0) model[vecs[v].wr] = vecs[v].wd;
        end
        @(negedge clk);
        scan_all("tbl");

        // Same-cycle write/read of r9: forwarded only in the bypass build
        @(negedge clk);
        RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'hA5A5A5A5;
        ReadReg1 = 5'd9; ReadReg2 = 5'd9;
        #1;
`ifdef REGBANK_BYPASS_EN
        chk("fwd_r9_p1", ReadData1, 32'hA5A5A5A5);
        chk("fwd_r9_p2", ReadData2, 32'hA5A5A5A5);
`else
        chk("fwd_r9_p1", ReadData1, 32'h0);
        chk("fwd_r9_p2", ReadData2, 32'h0);
`endif
        @(negedge clk);
        RegWrite = 1'b0;
        #1;
        chk("post_r9_p1", ReadData1, 32'hA5A5A5A5);
        chk("post_r9_p2", ReadData2, 32'hA5A5A5A5);
        model[9] = 32'hA5A5A5A5;

        // r0 is never forwarded nor written
        @(negedge clk);
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF;
        ReadReg1 = 5'd0; ReadReg2 = 5'd0;
        #1;
        chk("r0_nofwd_p1", ReadData1, 32'h0);
        chk("r0_nofwd_p2", ReadData2, 32'h0);
        @(negedge clk);
        RegWrite = 1'b0;
        #1;
        chk("r0_after_p1", ReadData1, 32'h0);

        // Back-to-back writes to r29, then reset with a competing write to r3
        @(negedge clk);
        RegWrite = 1'b1; WriteReg = 5'd29; WriteData = 32'h00000050;
        @(negedge clk);
        WriteData = 32'h00000100;
        @(negedge clk);
        RegWrite = 1'b0; ReadReg1 = 5'd29; ReadReg2 = 5'd3;
        #1;
        chk("r29_last_wins", ReadData1, 32'h00000100);
        chk("r3_before_rst", ReadData2, 32'h0);
        @(negedge clk);
        reset = 1'b1; RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h7;
        @(negedge clk);
        reset = 1'b0; RegWrite = 1'b0; ReadReg1 = 5'd29; ReadReg2 = 5'd3;
        #1;
        chk("rst_r29", ReadData1, SP_EXP);
        chk("rst_r3", ReadData2, 32'h0);
        model_reset();
        scan_all("rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter: DATA_W, default 32, width of each register and of all data ports.
REQ-002 Parameter: SP_INIT, default 227, value loaded into register 29 ($sp) on reset.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  reset, synchronous and active-high.
REQ-005 Port: RegWrite  input  1  write enable for the write port.
REQ-006 Port: ReadReg1  input  5  register index for read port 1.
REQ-007 Port: ReadReg2  input  5  register index for read port 2.
REQ-008 Port: WriteReg  input  5  destination register index, driven by the 4:1 5-bit destination-select mux.
REQ-009 Port: WriteData  input  DATA_W  data to write.
REQ-010 Port: ReadData1  output  DATA_W  contents of register ReadReg1.
REQ-011 Port: ReadData2  output  DATA_W  contents of register ReadReg2.

Function
REQ-012 The block SHALL hold 32 registers of DATA_W bits, indexed 0..31.
REQ-013 Read ports SHALL be combinational: ReadDataN reflects the addressed register with no clock latency.
REQ-014 On a rising edge with reset=0, RegWrite=1 and WriteReg!=0, register[WriteReg] SHALL take WriteData; the new value is visible on read ports from the following cycle (1-cycle write latency).
REQ-015 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded with no side effect.
REQ-016 With RegWrite=0 no register SHALL change, whatever the values on WriteReg and WriteData.
REQ-017 Both read ports SHALL be independent; the same index on both SHALL return identical data.
REQ-018 All 5-bit indices SHALL be fully decoded; there are no illegal or X-producing indices.
REQ-019 Back-to-back writes to the same index on consecutive edges SHALL each take effect; the last write wins.
REQ-020 An X or Z on WriteReg with RegWrite=1 is a protocol violation; the bench SHALL flag it with an assertion.

Reset
REQ-021 On a rising edge with reset=1, registers 1..28 and 30..31 SHALL become 0 and register 29 SHALL become SP_INIT.
REQ-022 Reset SHALL override RegWrite; a write requested in a reset cycle is discarded.
REQ-023 Reset asserted mid-operation SHALL take effect at the next edge regardless of prior writes.
REQ-024 After reset, ReadData1/ReadData2 SHALL be 0 for every index except 29, which returns SP_INIT.

Configuration
REQ-025 Macro REGBANK_BYPASS_EN: when defined, a read index equal to a non-zero WriteReg while RegWrite=1 and reset=0 SHALL return WriteData in the same cycle (write-to-read forwarding).
REQ-026 When REGBANK_BYPASS_EN is undefined, that read SHALL return the stored value from before the edge; register 0 SHALL never be forwarded in either build.

Verification
REQ-027 Reset, then read all 32 indices -> all 0 except index 29 = 227.
REQ-028 Write 0xDEADBEEF to r8 with RegWrite=1, then read r8 on both ports next cycle -> 0xDEADBEEF on ReadData1 and ReadData2.
REQ-029 Write 0x12345678 to r0 -> r0 reads 0; no other register changes.
REQ-030 RegWrite=0 with WriteReg=5, WriteData=0xFFFFFFFF -> r5 keeps its prior value (0).
REQ-031 Same cycle: write r9=0xA5A5A5A5 and read r9 -> 0xA5A5A5A5 with REGBANK_BYPASS_EN, old value 0 without; after the edge both builds return 0xA5A5A5A5.
REQ-032 Write r29=0x100, then assert reset together with RegWrite=1 on r3=7 -> r29=227, r3=0.
